// File: rtl/ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control path.
package ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned RD_W     = 5;

    // Base opcodes handled by the control FSM
    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_IMM    = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_LUI    = 3'd6,
        CLS_ILL    = 3'd7
    } opclass_t;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OP_PASS_B = 2'b11;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic PC_SEL_PC4 = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

endpackage

// File: rtl/ctrl_opclass.sv
// Opcode to instruction-class decoder with a legal flag; purely combinational.
module ctrl_opclass
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass_c,
    output logic       legal_c
);

    // Map each supported opcode to its class; anything else is illegal
    always_comb begin
        opclass_c = CLS_ILL;
        legal_c   = 1'b1;
        case (opcode)
            OP_R:      opclass_c = CLS_R;
            OP_IMM:    opclass_c = CLS_IMM;
            OP_LOAD:   opclass_c = CLS_LOAD;
            OP_STORE:  opclass_c = CLS_STORE;
            OP_BRANCH: opclass_c = CLS_BRANCH;
            OP_JAL:    opclass_c = CLS_JAL;
            OP_LUI:    opclass_c = CLS_LUI;
            default:   legal_c   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the RV32I core.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
// Datapath controls decode from the registered state (plus the IR fields and
// the ready/branch status of the current cycle), so an asynchronous reset
// drops every request and write enable at once.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [1:0] trap_cause
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam int unsigned WAIT_W   = (MEM_WAIT_MAX == 0) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    // Trap fires in the cycle whose wait would make the counter hit the limit
    localparam int unsigned WAIT_LIM = (MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1;
    localparam logic        TMO_EN   = (MEM_WAIT_MAX != 0);

    // Reject a zero-width counter configuration at elaboration
    if (CNT_W == 0) begin : g_cnt_w_check
        $error("multicycle_ctrl: CNT_W must be at least 1");
    end

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_inc;
    logic                wait_lim;
    logic [1:0]          cause_d;
    opclass_t            opclass;
    logic                legal;

    ctrl_opclass u_opclass (
        .opcode    (opcode),
        .opclass_c (opclass),
        .legal_c   (legal)
    );

    assign wait_lim = TMO_EN && (wait_cnt == WAIT_W'(WAIT_LIM));

    // State, trap flag and cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            trap       <= 1'b0;
            trap_cause <= TRAP_NONE;
        end else begin
            state_q    <= state_d;
            trap       <= (state_d == ST_TRAP);
            trap_cause <= cause_d;
        end
    end

    // Memory wait counter: counts stalled FETCH/MEM cycles, clears otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d   = state_q;
        cause_d   = trap_cause;
        wait_inc  = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PC4;
        alu_src_b = 1'b0;
        alu_op    = ALU_OP_ADD;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;

        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_PC4;
                    state_d = ST_DECODE;
                end else if (wait_lim) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (opclass)
                    CLS_R: begin
                        alu_op  = ALU_OP_FUNCT;
                        state_d = ST_WB;
                    end
                    CLS_IMM: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_OP_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_LUI: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_OP_PASS_B;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_OP_ADD;
                        state_d   = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op  = ALU_OP_SUB;
                        pc_we   = branch_taken;
                        pc_sel  = PC_SEL_ALU;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_ALU;
                        alu_op  = ALU_OP_ADD;
                        state_d = ST_WB;
                    end
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opclass == CLS_STORE);
                if (dmem_ready) begin
                    state_d = (opclass == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (wait_lim) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_we  = (rd != 5'd0);
                wb_sel  = (opclass == CLS_LOAD) ? WB_SEL_MEM :
                          (opclass == CLS_JAL)  ? WB_SEL_PC4 : WB_SEL_ALU;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire_c;

    assign retire_c = (state_d == ST_FETCH) &&
                      ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

    // Cycle and retired-instruction counters; idle in RST, frozen in TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if ((state_q != ST_RST) && (state_q != ST_TRAP)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire_c) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Performance counters not built in this configuration
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle
// tables are generated from the instruction class and chosen wait counts.
module tb_multicycle_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 32;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic        imr;
        logic        dmr;
        logic        bt;
        outs_t       o;
    } cyc_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic       imem_ready, dmem_ready, branch_taken;
    logic       imem_req, ir_we, pc_we, pc_sel, alu_src_b, dmem_req, dmem_we, reg_we, trap;
    logic [1:0] alu_op, wb_sel, trap_cause;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

    outs_t outs;
    assign outs = {imem_req, ir_we, pc_we, pc_sel, alu_src_b, alu_op,
                   dmem_req, dmem_we, reg_we, wb_sel, trap, trap_cause};

    int   total;
    int   bad;
    cyc_t exp_q[$];

    multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd(rd),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [31:0] instr, input logic imr, input logic dmr,
                                 input logic btv, input outs_t o);
        cyc_t c;
        c.instr = instr; c.imr = imr; c.dmr = dmr; c.bt = btv; c.o = o;
        exp_q.push_back(c);
    endfunction

    function automatic void push_trap(input logic [31:0] instr, input logic [1:0] cause);
        outs_t o;
        o = '0; o.trap = 1'b1; o.trap_cause = cause;
        for (int i = 0; i < 4; i++) push(instr, rnd(), rnd(), rnd(), o);
    endfunction

    // Reference: expected per-cycle controls for one instruction starting in FETCH
    function automatic void gen_instr(input logic [31:0] instr, input int fw, input int mw,
                                      input logic bt);
        logic [6:0] op;
        logic [4:0] r;
        outs_t      o;
        op = instr[6:0];
        r  = instr[11:7];
        for (int i = 0; i < fw && i < int'(WAIT_MAX); i++) begin
            o = '0; o.imem_req = 1'b1;
            push(instr, 1'b0, rnd(), rnd(), o);
        end
        if (fw >= int'(WAIT_MAX)) begin
            push_trap(instr, 2'b10);
            return;
        end
        o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
        push(instr, 1'b1, rnd(), rnd(), o);
        o = '0;
        push(instr, rnd(), rnd(), rnd(), o);
        case (op)
            7'h33, 7'h13, 7'h37, 7'h6F: begin
                o = '0;
                if (op == 7'h6F) begin
                    o.pc_we = 1'b1; o.pc_sel = 1'b1; o.alu_op = 2'b00;
                end else begin
                    o.alu_src_b = (op != 7'h33);
                    o.alu_op    = (op == 7'h37) ? 2'b11 : 2'b10;
                end
                push(instr, rnd(), rnd(), rnd(), o);
                o = '0; o.reg_we = (r != 5'd0); o.wb_sel = (op == 7'h6F) ? 2'b10 : 2'b00;
                push(instr, rnd(), rnd(), rnd(), o);
            end
            7'h03, 7'h23: begin
                o = '0; o.alu_src_b = 1'b1; o.alu_op = 2'b00;
                push(instr, rnd(), rnd(), rnd(), o);
                o = '0; o.dmem_req = 1'b1; o.dmem_we = (op == 7'h23);
                for (int i = 0; i < mw && i < int'(WAIT_MAX); i++) push(instr, rnd(), 1'b0, rnd(), o);
                if (mw >= int'(WAIT_MAX)) begin
                    push_trap(instr, 2'b10);
                    return;
                end
                push(instr, rnd(), 1'b1, rnd(), o);
                if (op == 7'h03) begin
                    o = '0; o.reg_we = (r != 5'd0); o.wb_sel = 2'b01;
                    push(instr, rnd(), rnd(), rnd(), o);
                end
            end
            7'h63: begin
                o = '0; o.alu_op = 2'b01; o.pc_sel = 1'b1; o.pc_we = bt;
                push(instr, rnd(), rnd(), bt, o);
            end
            default: push_trap(instr, 2'b01);
        endcase
    endfunction

    task automatic drive(input cyc_t c);
        imem_ready   = c.imr;
        dmem_ready   = c.dmr;
        branch_taken = c.bt;
        opcode       = c.instr[6:0];
        rd           = c.instr[11:7];
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (outs !== outs_t'(0)) begin bad++; $display("FAIL reset_hold got=%h exp=0", outs); end
`ifdef MULTICYCLE_CTRL_PERF_EN
        total++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== outs_t'(0)) begin bad++; $display("FAIL rst_state got=%h exp=0", outs); end
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (outs !== outs_t'(15'h4000)) begin bad++; $display("FAIL first_fetch got=%h exp=4000", outs); end
    endtask

    task automatic test_rtype();
        apply_reset();
        gen_instr(32'h002081B3, 0, 0, 1'b0);
        gen_instr(32'h00000013, 0, 0, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL rtype cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        apply_reset();
        gen_instr(32'h0000A183, 0, 3, 1'b0);
        gen_instr(32'h0000A183, 3, 0, 1'b0);
        gen_instr(32'h002081B3, 0, 0, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL load_wait cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        apply_reset();
        gen_instr(32'h00208463, 0, 0, 1'b1);
        gen_instr(32'h00208463, 0, 0, 1'b0);
        gen_instr(32'h0040006F, 0, 0, 1'b0);
        gen_instr(32'h0020A023, 0, 1, 1'b0);
        gen_instr(32'h002081B3, 0, 0, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL branch cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
    endtask

    // Illegal opcode traps, stays sticky, and is cleared by an rst_n pulse
    task automatic test_illegal();
        apply_reset();
        gen_instr(32'h0000007F, 1, 0, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL illegal cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs !== outs_t'(0)) begin bad++; $display("FAIL illegal_clear got=%h exp=0", outs); end
        @(posedge clk); #1;
        rst_n = 1'b1; imem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (outs !== outs_t'(15'h4000)) begin bad++; $display("FAIL illegal_recover got=%h exp=4000", outs); end
    endtask

    task automatic test_fetch_timeout();
        apply_reset();
        gen_instr(32'h00000013, 3, 0, 1'b0);
        gen_instr(32'h002081B3, 4, 0, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL fetch_tmo cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_timeout();
        apply_reset();
        gen_instr(32'h0020A023, 0, 3, 1'b0);
        gen_instr(32'h0020A023, 0, 6, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL mem_tmo cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_store();
        apply_reset();
        gen_instr(32'h0020A023, 0, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL mid_store cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs !== outs_t'(0)) begin bad++; $display("FAIL mid_store_drop got=%h exp=0", outs); end
`ifdef MULTICYCLE_CTRL_PERF_EN
        total++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            bad++; $display("FAIL mid_store_perf got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Random back-to-back legal instructions with random waits and rd
    task automatic test_random();
        logic [6:0]  ops [7];
        logic [31:0] instr;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            instr = $urandom();
            instr[6:0] = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) instr[11:7] = 5'd0;
            gen_instr(instr, int'($urandom_range(0, WAIT_MAX - 1)),
                      int'($urandom_range(0, WAIT_MAX - 1)), rnd());
        end
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    // R (4 cycles) + BRANCH (3) + illegal (FETCH, DECODE, then frozen): 9 cycles, 2 retired
    task automatic test_perf();
        apply_reset();
        gen_instr(32'h002081B3, 0, 0, 1'b0);
        gen_instr(32'h00208463, 0, 0, 1'b1);
        gen_instr(32'h0000007F, 0, 0, 1'b0);
        foreach (exp_q[i]) begin
            drive(exp_q[i]); total++;
            if (outs !== exp_q[i].o) begin bad++; $display("FAIL perf cyc=%0d got=%h exp=%h", i, outs, exp_q[i].o); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (cycle_cnt !== CNT_W'(9)) begin bad++; $display("FAIL perf_cycle got=%0d exp=9", cycle_cnt); end
        total++;
        if (instret_cnt !== CNT_W'(2)) begin bad++; $display("FAIL perf_instret got=%0d exp=2", instret_cnt); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        opcode = 7'd0; rd = 5'd0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_illegal();
        test_fetch_timeout();
        test_mem_timeout();
        test_reset_mid_store();
        test_random();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
